// File: rtl/bird_pkg.sv
// bird_pkg
// Shared definitions for the bird game blocks (motion controller, renderer,
// pipe checker).
//   bird_state_t : game state encoding, also exported on the HUD/debug port
//   DEF_*        : default geometry and physics constants
package bird_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } bird_state_t;

    localparam int DEF_Y_WIDTH  = 7;
    localparam int DEF_V_WIDTH  = 5;
    localparam int DEF_Y_TOP    = 0;
    localparam int DEF_Y_BOTTOM = 119;
    localparam int DEF_START_Y  = 60;
    localparam int DEF_GRAVITY  = 1;
    localparam int DEF_FLAP_VEL = 4;
    localparam int DEF_MAX_FALL = 6;

endpackage

// File: rtl/key_edge.sv
// key_edge
// Registered rising-edge detector for a synchronous key level. A held key
// yields exactly one single-clock pulse, one clock after the level rises.
// Ports:
//   clk   in  : system clock
//   reset in  : asynchronous reset, active-high
//   key   in  : synchronous (debounced) key level
//   rise  out : one-clock pulse on each 0->1 transition of key
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic prev_reg;
    logic rise_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            prev_reg <= key;
            rise_reg <= key & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl
// Game-state FSM plus vertical physics for the bird. Velocity (signed,
// positive = down) gains gravity on each frame tick up to a terminal speed;
// a flap sets an upward velocity. Position is clamped at ceiling and floor.
// Physics advance only on tick while running; state control runs every clock.
// Configuration macro:
//   BIRD_CEILING_KILL_EN : when defined, reaching the ceiling ends the game;
//                          otherwise the ceiling only clamps.
// Ports:
//   clk       in  : system clock
//   reset     in  : asynchronous reset, active-high
//   press_key in  : debounced key level (rising edge = flap / start / restart)
//   touched   in  : collision from the pipe checker
//   tick      in  : one-clock frame enable
//   start     out : one-clock pulse when a game begins
//   move      out : high while running
//   game_over out : high when stopped
//   bird_y    out : current row
//   bird_vel  out : current signed velocity
//   state     out : state encoding for debug/HUD
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int Y_WIDTH  = DEF_Y_WIDTH,
    parameter int V_WIDTH  = DEF_V_WIDTH,
    parameter int Y_TOP    = DEF_Y_TOP,
    parameter int Y_BOTTOM = DEF_Y_BOTTOM,
    parameter int START_Y  = DEF_START_Y,
    parameter int GRAVITY  = DEF_GRAVITY,
    parameter int FLAP_VEL = DEF_FLAP_VEL,
    parameter int MAX_FALL = DEF_MAX_FALL
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      press_key,
    input  logic                      touched,
    input  logic                      tick,
    output logic                      start,
    output logic                      move,
    output logic                      game_over,
    output logic [Y_WIDTH-1:0]        bird_y,
    output logic signed [V_WIDTH-1:0] bird_vel,
    output logic [1:0]                state
);

    // Position math is done with two extra bits so that overshoot past either
    // bound (negative or beyond 2^Y_WIDTH-1) is still representable.
    localparam int YW2 = Y_WIDTH + 2;
    localparam int VW1 = V_WIDTH + 1;

    localparam logic signed [V_WIDTH-1:0] VEL_FLAP = V_WIDTH'(-FLAP_VEL);
    localparam logic signed [V_WIDTH-1:0] VEL_MAX  = V_WIDTH'(MAX_FALL);
    localparam logic signed [VW1-1:0]     VEL_MAXW = VW1'(MAX_FALL);
    localparam logic signed [VW1-1:0]     GRAV_W   = VW1'(GRAVITY);
    localparam logic signed [YW2-1:0]     Y_TOP_W  = YW2'(Y_TOP);
    localparam logic signed [YW2-1:0]     Y_BOT_W  = YW2'(Y_BOTTOM);

    logic key_rise;

    bird_state_t state_reg, state_next;
    logic [Y_WIDTH-1:0]        y_reg, y_next;
    logic signed [V_WIDTH-1:0] vel_reg, vel_next;
    logic                      flap_pending_reg, flap_pending_next;

    logic signed [VW1-1:0]     vel_fall;
    logic signed [V_WIDTH-1:0] v_new;
    logic signed [YW2-1:0]     y_sum;
    logic                      flap_now;
    logic                      hit_floor;
    logic                      hit_ceil;

    key_edge u_key_edge (
        .clk   (clk),
        .reset (reset),
        .key   (press_key),
        .rise  (key_rise)
    );

    // ---------------- physics datapath ----------------
    // A key edge arriving in the same clock as the tick counts as a flap
    // for that tick, so it is OR-ed with the pending flag here.
    assign flap_now  = flap_pending_reg | key_rise;
    assign vel_fall  = $signed({vel_reg[V_WIDTH-1], vel_reg}) + GRAV_W;
    assign v_new     = flap_now ? VEL_FLAP :
                       (vel_fall > VEL_MAXW) ? VEL_MAX : vel_fall[V_WIDTH-1:0];
    assign y_sum     = $signed({2'b00, y_reg}) + YW2'(v_new);
    assign hit_floor = (y_sum >= Y_BOT_W);
    assign hit_ceil  = (y_sum <= Y_TOP_W);

    always_comb begin
        y_next            = y_reg;
        vel_next          = vel_reg;
        flap_pending_next = flap_pending_reg;
        case (state_reg)
            ST_START: begin
                y_next            = Y_WIDTH'(START_Y);
                vel_next          = '0;
                flap_pending_next = 1'b0;
            end
            ST_RUN: begin
                // A collision freezes everything, even when a tick coincides.
                if (!touched) begin
                    if (tick) begin
                        flap_pending_next = 1'b0;
                        if (hit_floor) begin
                            y_next   = Y_WIDTH'(Y_BOTTOM);
                            vel_next = '0;
                        end else if (hit_ceil) begin
                            y_next   = Y_WIDTH'(Y_TOP);
                            vel_next = '0;
                        end else begin
                            y_next   = y_sum[Y_WIDTH-1:0];
                            vel_next = v_new;
                        end
                    end else if (key_rise) begin
                        flap_pending_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_reg            <= Y_WIDTH'(START_Y);
            vel_reg          <= '0;
            flap_pending_reg <= 1'b0;
        end else begin
            y_reg            <= y_next;
            vel_reg          <= vel_next;
            flap_pending_reg <= flap_pending_next;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_READY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_READY: if (key_rise) state_next = ST_START;
            ST_START: state_next = ST_RUN;
            ST_RUN: begin
                if (touched) begin
                    state_next = ST_STOP;
                end else if (tick && hit_floor) begin
                    state_next = ST_STOP;
                end
`ifdef BIRD_CEILING_KILL_EN
                else if (tick && hit_ceil) begin
                    state_next = ST_STOP;
                end
`endif
            end
            ST_STOP: if (key_rise) state_next = ST_READY;
            default: state_next = ST_READY;
        endcase
    end

    // ---------------- FSM: outputs (decoded from registers only) ----------------
    always_comb begin
        start     = 1'b0;
        move      = 1'b0;
        game_over = 1'b0;
        case (state_reg)
            ST_START: start     = 1'b1;
            ST_RUN:   move      = 1'b1;
            ST_STOP:  game_over = 1'b1;
            default: ;
        endcase
    end

    assign state    = state_reg;
    assign bird_y   = y_reg;
    assign bird_vel = vel_reg;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
module tb_bird_motion_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              press_key = 1'b0;
    logic              touched = 1'b0;
    logic              tick = 1'b0;
    logic              start;
    logic              move;
    logic              game_over;
    logic [6:0]        bird_y;
    logic signed [4:0] bird_vel;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    // Hand-computed free-fall trajectory from y=60, vel=0 (gravity 1, max 6).
    int ff_vel[13] = '{1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 6, 6, 0};
    int ff_y[13]   = '{61, 63, 66, 70, 75, 81, 87, 93, 99, 105, 111, 117, 119};

    bird_motion_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .press_key (press_key),
        .touched   (touched),
        .tick      (tick),
        .start     (start),
        .move      (move),
        .game_over (game_over),
        .bird_y    (bird_y),
        .bird_vel  (bird_vel),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release then press: rise pulse is high after the second step, acted on
    // by the FSM at the third.
    task automatic press_edge();
        press_key = 1'b0;
        step();
        press_key = 1'b1;
        step();
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        // ---- reset ----
        #12;
        check("rst_state", state, 0);
        check("rst_y", bird_y, 60);
        check("rst_vel", bird_vel, 0);
        check("rst_flags", {start, move, game_over}, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        // ---- start latency ----
        press_key = 1'b1;
        step();
        check("start_early", start, 0);
        step();
        check("start_pulse", start, 1);
        check("start_state", state, 1);
        step();
        check("start_done", start, 0);
        check("run_move", move, 1);
        check("run_y", bird_y, 60);
        check("run_vel", bird_vel, 0);
        $display("start: state=%0d y=%0d vel=%0d", state, bird_y, bird_vel);

        // ---- free fall, terminal velocity, floor ----
        for (int i = 0; i < 13; i++) begin
            do_tick();
            check($sformatf("fall_vel%0d", i), bird_vel, ff_vel[i]);
            check($sformatf("fall_y%0d", i), bird_y, ff_y[i]);
            check($sformatf("fall_state%0d", i), state, (i == 12) ? 3 : 2);
            $display("fall tick %0d: vel=%0d y=%0d state=%0d", i, bird_vel, bird_y, state);
            step();
        end
        check("floor_game_over", game_over, 1);
        do_tick();
        check("stop_tick_ignored", bird_y, 119);

        // ---- restart ----
        press_edge();
        check("stop_to_ready", state, 0);
        press_edge();
        check("ready_to_start", start, 1);
        step();
        check("restart_y", bird_y, 60);
        check("restart_run", state, 2);

        // ---- flap held across 5 ticks ----
        press_key = 1'b0;
        step();
        press_key = 1'b1;
        step();
        begin
            int fv[5] = '{-4, -3, -2, -1, 0};
            int fy[5] = '{56, 53, 51, 50, 50};
            for (int i = 0; i < 5; i++) begin
                do_tick();
                check($sformatf("flap_vel%0d", i), bird_vel, fv[i]);
                check($sformatf("flap_y%0d", i), bird_y, fy[i]);
                $display("flap tick %0d: vel=%0d y=%0d", i, bird_vel, bird_y);
                step();
            end
        end

        // ---- collision together with tick ----
        touched = 1'b1;
        tick = 1'b1;
        step();
        touched = 1'b0;
        tick = 1'b0;
        check("touch_state", state, 3);
        check("touch_game_over", game_over, 1);
        check("touch_y", bird_y, 50);
        check("touch_vel", bird_vel, 0);
        $display("touch: state=%0d y=%0d", state, bird_y);

        // ---- ceiling ----
        press_edge();
        press_edge();
        step();
        check("ceil_run", state, 2);
        for (int i = 1; i <= 15; i++) begin
            press_key = 1'b0;
            step();
            press_key = 1'b1;
            step();
            do_tick();
            check($sformatf("ceil_y%0d", i), bird_y, (i < 15) ? 60 - 4 * i : 0);
            check($sformatf("ceil_vel%0d", i), bird_vel, (i < 15) ? -4 : 0);
            $display("ceiling flap %0d: y=%0d vel=%0d state=%0d", i, bird_y, bird_vel, state);
        end
`ifdef BIRD_CEILING_KILL_EN
        check("ceil_state", state, 3);
        step();
        do_tick();
        check("ceil_after_y", bird_y, 0);
`else
        check("ceil_state", state, 2);
        step();
        do_tick();
        check("ceil_after_y", bird_y, 1);
        check("ceil_after_vel", bird_vel, 1);
`endif

        // ---- asynchronous reset mid-game ----
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_state", state, 0);
        check("areset_y", bird_y, 60);
        check("areset_vel", bird_vel, 0);
        check("areset_flags", {start, move, game_over}, 0);
        $display("async reset: state=%0d y=%0d vel=%0d", state, bird_y, bird_vel);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_reset_ready", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Parametrised successor to the bird control FSM. It owns the bird's game state and its vertical physics: signed velocity with gravity, flap impulse, terminal velocity, and ceiling/floor bounds. It sits between the key input and the bird renderer, and drives `bird_y` directly instead of emitting bare `move` pulses. Physics advance only on a frame `tick`; state control (start, stop, restart) runs every clock.

## Interface
Parameters:
- `Y_WIDTH`, default 7: width of `bird_y` (unsigned pixel row).
- `V_WIDTH`, default 5: width of signed velocity.
- `Y_TOP`, default 0: ceiling row.
- `Y_BOTTOM`, default 119: floor row.
- `START_Y`, default 60: row loaded on start.
- `GRAVITY`, default 1: velocity increment per tick.
- `FLAP_VEL`, default 4: upward speed magnitude applied by a flap.
- `MAX_FALL`, default 6: terminal downward velocity.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous reset, active-high.
- `press_key` in 1: synchronous level from the key debouncer.
- `touched` in 1: collision from the pipe checker, sampled every clock.
- `tick` in 1: one-clock frame enable.
- `start` out 1: one-clock pulse when a game begins.
- `move` out 1: high in RUN.
- `game_over` out 1: high in STOP.
- `bird_y` out `Y_WIDTH`: current row.
- `bird_vel` out `V_WIDTH` signed: current velocity; positive means down.
- `state` out 2: state encoding, for debug/HUD.

## Operation
- **Reset.** Outputs take these values: state=READY, `bird_y`=START_Y, `bird_vel`=0, `start`=`move`=`game_over`=0, flap_pending=0.
- **Key handling.** `press_key` is rising-edge detected. Holding the key produces one flap only.
- **READY.** A key edge moves to START.
- **START.** Lasts exactly one clock; `start`=1. Loads `bird_y`=START_Y and `bird_vel`=0, clears flap_pending, then moves to RUN.
- **RUN.** A key edge sets flap_pending. On `tick`:
  - v_new = flap_pending ? −FLAP_VEL : min(vel+GRAVITY, MAX_FALL).
  - y_next = y + v_new, computed at Y_WIDTH+2 signed bits.
  - Both registers take the new values, and flap_pending clears.
- **Floor.** If y_next ≥ Y_BOTTOM: `bird_y`=Y_BOTTOM, `bird_vel`=0, next state is STOP.
- **Ceiling.** If y_next ≤ Y_TOP: `bird_y`=Y_TOP, `bird_vel`=0. Behaviour depends on the macro (see Configuration).
- **Collision.** `touched`=1 in RUN moves to STOP on the next clock with or without `tick`. Position and velocity freeze.
- **STOP.** `game_over`=1. Position is held. A key edge moves to READY. `bird_y` is not changed until START.
- **Simultaneous events.**
  - `touched` and `tick` in the same clock: `touched` wins and no physics update occurs.
  - Key edge and `tick` in the same clock: the flap applies to this tick.
- **Parameters.** Legal only if Y_TOP < START_Y < Y_BOTTOM < 2^Y_WIDTH and FLAP_VEL, MAX_FALL < 2^(V_WIDTH−1).

## Timing
- Registered outputs; no combinational path from inputs to outputs.
- Key edge to `start` pulse: 2 clocks. One clock is for edge detection, one for READY→START.
- `tick` to updated `bird_y`/`bird_vel`: 1 clock.
- `touched` to `game_over`: 1 clock.
- `reset` asserted mid-game returns all outputs to reset values immediately (async). The first clock edge after deassertion sees READY.
- `tick` outside RUN is ignored.

## Configuration
- **`BIRD_CEILING_KILL_EN` defined.** Reaching the ceiling is fatal: clamp `bird_y` to Y_TOP and go to STOP, same as the floor.
- **`BIRD_CEILING_KILL_EN` undefined.** The ceiling only clamps: `bird_y`=Y_TOP, `bird_vel`=0, remain in RUN.

## Structure
- **Package `bird_pkg`.** Holds the state enum (READY=2'd0, START=2'd1, RUN=2'd2, STOP=2'd3) and default physics constants shared with the renderer and pipe checker.
- **Sub-module `key_edge`.** Registered rising-edge detector, reused by other key consumers.
- **Top level.** FSM, physics datapath, clamp logic.

## Test plan
All scenarios use default parameters.
- **Start.** Reset, then a press edge → `start` pulse exactly 2 clocks later; `bird_y`=60, `bird_vel`=0, `move`=1 on the following clock.
- **Free fall.** 3 ticks with no press → (vel, y) = (1,61), (2,63), (3,66).
- **Terminal velocity.** Continue to fall → `bird_vel` saturates at 6 and y increments by 6 per tick.
- **Floor.** Fall until y_next ≥ 119 → `bird_y`=119, STOP on the next clock, `game_over`=1.
- **Flap.** Press held across 5 ticks from y=60, vel=0 → first tick vel=−4, y=56; following ticks apply gravity (vel −3, y=53), with no second flap while held.
- **Collision, ceiling and reset.**
  - `touched` pulsed together with `tick` → STOP, y unchanged.
  - Ceiling hit in each macro build → RUN retained with y=0 (macro undefined) or STOP (macro defined).
  - `reset` mid-RUN → immediate reset values.
